// File: rtl/fake_psx_pkg.sv
// ---------------------------------------------------------------------------
// fake_psx_pkg
//
// Shared definitions for the fake PSX pad responder:
//   - psx_state_e     : responder FSM states
//   - PSX_CMD_*       : command bytes a console sends in a digital-pad poll
//   - PSX_PAD_*       : fixed reply bytes of a digital pad
//   - PSX_FRAME_BYTES : number of bytes in one poll frame
//   - psx_reply_byte  : reply byte for a given byte index of the frame
// ---------------------------------------------------------------------------
package fake_psx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SHIFT     = 3'd1,
        ST_ACK_WAIT  = 3'd2,
        ST_ACK_PULSE = 3'd3,
        ST_DONE      = 3'd4,
        ST_IGNORE    = 3'd5
    } psx_state_e;

    localparam logic [7:0] PSX_CMD_START   = 8'h01;
    localparam logic [7:0] PSX_CMD_POLL    = 8'h42;
    localparam logic [7:0] PSX_PAD_READY   = 8'h5A;
    localparam logic [7:0] PSX_PAD_IDLE    = 8'hFF;
    localparam int         PSX_FRAME_BYTES = 5;

    // Reply byte sent while the host clocks byte `idx` of the frame.
    // Indices past the last byte fall back to the idle pattern.
    function automatic logic [7:0] psx_reply_byte(
        input logic [2:0]  idx,
        input logic [7:0]  pad_id,
        input logic [15:0] btn
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = PSX_PAD_IDLE;
            3'd1:    b = pad_id;
            3'd2:    b = PSX_PAD_READY;
            3'd3:    b = btn[7:0];
            3'd4:    b = btn[15:8];
            default: b = PSX_PAD_IDLE;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/fake_psx_pad_sync.sv
// ---------------------------------------------------------------------------
// psx_sync_edge
//
// Two-flop synchronizer for one asynchronous host line, plus single-cycle
// rise/fall pulses derived from the synchronized level. All flops reset to 1
// because every PSX host line idles high, so leaving reset never produces a
// spurious edge while the host is idle.
//
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous, active-high reset
//   d     in   raw asynchronous line
//   q     out  synchronized level (two clk of latency)
//   rise  out  one-cycle pulse, synchronized level went 0 -> 1
//   fall  out  one-cycle pulse, synchronized level went 1 -> 0
// ---------------------------------------------------------------------------
module psx_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= d;
            sync <= meta;
            prev <= sync;
        end
    end

    // Edge pulses are combinational from the second sync flop so that a
    // registered consumer acts on the third clk after the pin changed.
    assign q    = sync;
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/fake_psx_pad.sv
// ---------------------------------------------------------------------------
// fake_psx_pad
//
// Controller-side responder for the PSX pad serial link. The host lines are
// oversampled on clk, the command stream is shifted in LSB first, and the
// standard 5-byte digital-pad reply (FF, PAD_ID, 5A, buttons lo, buttons hi)
// is shifted out on `data`. Between bytes 0..3 an active-low `ack` pulse is
// produced; after byte 4 the pad waits for attention to be released.
//
// Parameters:
//   ACK_DELAY  clk cycles from the synced 8th psx_clk rise to ack falling (>=1)
//   ACK_WIDTH  clk cycles ack is held low (>=1)
//   PAD_ID     ID byte returned in byte 1
//
// Ports:
//   clk          in   system clock, >=16x the psx_clk frequency
//   rst          in   asynchronous, active-high reset
//   att          in   host attention, active-low, asynchronous
//   psx_clk      in   host serial clock, idle high, asynchronous
//   cmd          in   host command bit, LSB first, asynchronous
//   buttons[15:0] in  button state, active-low, latched at frame start
//   data         out  reply bit, idle high
//   ack          out  byte acknowledge, active-low pulse
//   frame_done   out  one-cycle pulse when a full frame ends with att high
//   frame_abort  out  one-cycle pulse when a frame is abandoned
//
// Optional feature:
//   FAKE_PSX_PAD_STRICT_CMD_EN  when defined, byte 0 must be 8'h01 and
//   byte 1 must be 8'h42; otherwise the frame is dropped without ack and
//   the pad stays silent until att is released.
//
// Valid/ready note: this block has no valid/ready handshake; the host link
// is self-timed by psx_clk edges and the ack pulse acts as the per-byte
// "ready for next byte" indication.
// ---------------------------------------------------------------------------
module fake_psx_pad
    import fake_psx_pkg::*;
#(
    parameter int         ACK_DELAY = 4,
    parameter int         ACK_WIDTH = 2,
    parameter logic [7:0] PAD_ID    = 8'h41
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        att,
    input  logic        psx_clk,
    input  logic        cmd,
    input  logic [15:0] buttons,
    output logic        data,
    output logic        ack,
    output logic        frame_done,
    output logic        frame_abort
);

    localparam int CNT_MAX = (ACK_DELAY > ACK_WIDTH) ? ACK_DELAY : ACK_WIDTH;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] DELAY_LAST = CW'(ACK_DELAY - 1);
    localparam logic [CW-1:0] WIDTH_LAST = CW'(ACK_WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [2:0]    LAST_BYTE  = 3'(PSX_FRAME_BYTES - 1);

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic att_level_unused;
    logic att_rise;
    logic att_fall;
    logic pclk_level_unused;
    logic pclk_rise;
    logic pclk_fall;
    logic cmd_s;
    logic cmd_rise_unused;
    logic cmd_fall_unused;

    psx_sync_edge u_sync_att (
        .clk  (clk),
        .rst  (rst),
        .d    (att),
        .q    (att_level_unused),
        .rise (att_rise),
        .fall (att_fall)
    );

    psx_sync_edge u_sync_pclk (
        .clk  (clk),
        .rst  (rst),
        .d    (psx_clk),
        .q    (pclk_level_unused),
        .rise (pclk_rise),
        .fall (pclk_fall)
    );

    psx_sync_edge u_sync_cmd (
        .clk  (clk),
        .rst  (rst),
        .d    (cmd),
        .q    (cmd_s),
        .rise (cmd_rise_unused),
        .fall (cmd_fall_unused)
    );

    // ------------------------------------------------------------------
    // Frame state
    // ------------------------------------------------------------------
    psx_state_e      state;
    logic [2:0]      bit_idx;
    logic [2:0]      byte_idx;
    logic [CW-1:0]   cnt;
    logic [15:0]     btn_latch;
    logic [7:0]      rx_byte;
    logic [7:0]      rx_next;
    logic [7:0]      tx_byte;
    logic            cmd_bad;
    logic            pclk_edge;

    assign tx_byte   = psx_reply_byte(byte_idx, PAD_ID, btn_latch);
    assign pclk_edge = pclk_rise | pclk_fall;

    // Received byte including the bit being sampled this cycle, so the
    // command check at the 8th rise sees all eight bits.
    always_comb begin
        rx_next          = rx_byte;
        rx_next[bit_idx] = cmd_s;
    end

`ifdef FAKE_PSX_PAD_STRICT_CMD_EN
    assign cmd_bad = ((byte_idx == 3'd0) && (rx_next != PSX_CMD_START)) ||
                     ((byte_idx == 3'd1) && (rx_next != PSX_CMD_POLL));
`else
    assign cmd_bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            bit_idx     <= 3'd0;
            byte_idx    <= 3'd0;
            cnt         <= '0;
            btn_latch   <= '0;
            rx_byte     <= '0;
            data        <= 1'b1;
            ack         <= 1'b1;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;

            case (state)
                ST_IDLE: begin
                    data <= 1'b1;
                    ack  <= 1'b1;
                    if (att_fall) begin
                        btn_latch <= buttons;
                        byte_idx  <= 3'd0;
                        bit_idx   <= 3'd0;
                        rx_byte   <= '0;
                        cnt       <= '0;
                        state     <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    // att release wins over any clock edge seen this cycle.
                    if (att_rise) begin
                        frame_abort <= 1'b1;
                        data        <= 1'b1;
                        ack         <= 1'b1;
                        state       <= ST_IDLE;
                    end else if (pclk_fall) begin
                        data <= tx_byte[bit_idx];
                    end else if (pclk_rise) begin
                        rx_byte <= rx_next;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= 3'd0;
                            if (cmd_bad) begin
                                frame_abort <= 1'b1;
                                data        <= 1'b1;
                                ack         <= 1'b1;
                                state       <= ST_IGNORE;
                            end else if (byte_idx == LAST_BYTE) begin
                                // No ack after the last byte.
                                data  <= 1'b1;
                                state <= ST_DONE;
                            end else begin
                                cnt   <= '0;
                                state <= ST_ACK_WAIT;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end

                ST_ACK_WAIT: begin
                    if (att_rise) begin
                        frame_abort <= 1'b1;
                        data        <= 1'b1;
                        ack         <= 1'b1;
                        cnt         <= '0;
                        state       <= ST_IDLE;
                    end else if (pclk_edge) begin
                        // Host clocked before our ack: protocol error.
                        frame_abort <= 1'b1;
                        data        <= 1'b1;
                        ack         <= 1'b1;
                        cnt         <= '0;
                        state       <= ST_IGNORE;
                    end else if (cnt == DELAY_LAST) begin
                        ack   <= 1'b0;
                        cnt   <= '0;
                        state <= ST_ACK_PULSE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                ST_ACK_PULSE: begin
                    if (att_rise) begin
                        frame_abort <= 1'b1;
                        data        <= 1'b1;
                        ack         <= 1'b1;
                        cnt         <= '0;
                        state       <= ST_IDLE;
                    end else if (pclk_edge) begin
                        frame_abort <= 1'b1;
                        data        <= 1'b1;
                        ack         <= 1'b1;
                        cnt         <= '0;
                        state       <= ST_IGNORE;
                    end else if (cnt == WIDTH_LAST) begin
                        ack     <= 1'b1;
                        cnt     <= '0;
                        bit_idx <= 3'd0;
                        // Saturate; the last byte never reaches this state.
                        if (byte_idx < LAST_BYTE) begin
                            byte_idx <= byte_idx + 3'd1;
                        end
                        state <= ST_SHIFT;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                ST_DONE: begin
                    data <= 1'b1;
                    if (att_rise) begin
                        frame_done <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end

                ST_IGNORE: begin
                    data <= 1'b1;
                    ack  <= 1'b1;
                    if (att_rise) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    data  <= 1'b1;
                    ack   <= 1'b1;
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fake_psx_pad.sv
// ---------------------------------------------------------------------------
// tb_fake_psx_pad
//
// Host-side driver for fake_psx_pad. The driver schedules, from the protocol
// rules, when each output level or pulse must appear (pin edge + 3 clk for
// data, 8th rise + 3 + ACK_DELAY for ack, ...). A compare process checks
// data/ack/frame_done/frame_abort on every falling clk edge against that
// schedule, and each frame's sampled reply bytes are checked against the
// expected reply and a few literal values.
// ---------------------------------------------------------------------------
module tb_fake_psx_pad;

    localparam int         ACK_DELAY = 4;
    localparam int         ACK_WIDTH = 2;
    localparam logic [7:0] PAD_ID    = 8'h41;
    localparam int         HALF      = 8;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        att;
    logic        psx_clk;
    logic        cmd;
    logic [15:0] buttons;
    logic        data;
    logic        ack;
    logic        frame_done;
    logic        frame_abort;

    fake_psx_pad #(
        .ACK_DELAY (ACK_DELAY),
        .ACK_WIDTH (ACK_WIDTH),
        .PAD_ID    (PAD_ID)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .att         (att),
        .psx_clk     (psx_clk),
        .cmd         (cmd),
        .buttons     (buttons),
        .data        (data),
        .ack         (ack),
        .frame_done  (frame_done),
        .frame_abort (frame_abort)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #(900000);
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- expectation schedule ----------------
    typedef struct {
        int   t;
        logic v;
    } lvl_ev_t;

    lvl_ev_t data_ev[$];
    lvl_ev_t ack_ev[$];
    int      done_ev[$];
    int      abort_ev[$];

    logic    exp_data = 1'b1;
    logic    exp_ack  = 1'b1;
    bit      chk_en   = 1'b0;
    lvl_ev_t ev_tmp;
    bit      want_done;
    bit      want_abort;
    logic    ack_prev = 1'b1;
    int      ack_falls = 0;
    int      done_cnt  = 0;
    int      abort_cnt = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            while (data_ev.size() > 0 && data_ev[0].t <= cyc) begin
                ev_tmp   = data_ev.pop_front();
                exp_data = ev_tmp.v;
            end
            while (ack_ev.size() > 0 && ack_ev[0].t <= cyc) begin
                ev_tmp  = ack_ev.pop_front();
                exp_ack = ev_tmp.v;
            end
            want_done = 1'b0;
            while (done_ev.size() > 0 && done_ev[0] <= cyc) begin
                if (done_ev[0] == cyc) want_done = 1'b1;
                void'(done_ev.pop_front());
            end
            want_abort = 1'b0;
            while (abort_ev.size() > 0 && abort_ev[0] <= cyc) begin
                if (abort_ev[0] == cyc) want_abort = 1'b1;
                void'(abort_ev.pop_front());
            end
            check("data", 64'(data), 64'(exp_data));
            check("ack", 64'(ack), 64'(exp_ack));
            check("frame_done", 64'(frame_done), 64'(want_done));
            check("frame_abort", 64'(frame_abort), 64'(want_abort));
            if (ack_prev && !ack) ack_falls++;
            ack_prev = ack;
            if (frame_done) done_cnt++;
            if (frame_abort) abort_cnt++;
        end
    end

    // ---------------- reference rules ----------------
    function automatic logic [7:0] reply_of(input int idx, input logic [15:0] btn);
        case (idx)
            0:       return 8'hFF;
            1:       return PAD_ID;
            2:       return 8'h5A;
            3:       return btn[7:0];
            default: return btn[15:8];
        endcase
    endfunction

    function automatic bit cmd_rejected(input int idx, input logic [7:0] c);
`ifdef FAKE_PSX_PAD_STRICT_CMD_EN
        return ((idx == 0) && (c != 8'h01)) || ((idx == 1) && (c != 8'h42));
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_data(input int t, input logic v);
        data_ev.push_back('{t, v});
    endtask

    task automatic model_reset();
        data_ev.delete();
        ack_ev.delete();
        done_ev.delete();
        abort_ev.delete();
        exp_data = 1'b1;
        exp_ack  = 1'b1;
    endtask

    // One host frame. stop_bit: raise att before this bit (-1 none);
    // early_byte: clock early during the ack wait after that byte (-1 none);
    // rst_byte: assert rst during the ack pulse after that byte (-1 none).
    task automatic run_frame(
        input  logic [15:0] btn,
        input  logic [15:0] btn_mid,
        input  int          mid_byte,
        input  logic [39:0] cmds,
        input  int          stop_bit,
        input  int          early_byte,
        input  int          rst_byte,
        output logic [39:0] got,
        output int          n_got
    );
        int         r;
        int         how;   // 0 full, 1 att abort, 2 ignored, 3 reset
        bit         ended;
        logic [7:0] rb;
        logic [7:0] cb;
        got   = '1;
        n_got = 0;
        ended = 1'b0;
        how   = 0;
        r     = 0;
        buttons = btn;
        wait_cyc(2);
        att = 1'b0;
        wait_cyc(HALF);
        for (int i = 0; i < 5 && !ended; i++) begin
            rb = reply_of(i, btn);
            cb = cmds[8*i +: 8];
            if (i == mid_byte) buttons = btn_mid;
            for (int b = 0; b < 8 && !ended; b++) begin
                if (i * 8 + b == stop_bit) begin
                    att = 1'b1;
                    abort_ev.push_back(cyc + 3);
                    push_data(cyc + 3, 1'b1);
                    ended = 1'b1;
                    how   = 1;
                end else begin
                    psx_clk = 1'b0;
                    cmd     = cb[b];
                    push_data(cyc + 3, rb[b]);
                    wait_cyc(HALF);
                    psx_clk = 1'b1;
                    got[8*i + b] = data;
                    n_got++;
                    r = cyc;
                    if (b < 7) wait_cyc(HALF);
                end
            end
            if (!ended) begin
                if (cmd_rejected(i, cb)) begin
                    abort_ev.push_back(r + 3);
                    push_data(r + 3, 1'b1);
                    ended = 1'b1;
                    how   = 2;
                end else if (i == 4) begin
                    push_data(r + 3, 1'b1);
                end else if (i == early_byte) begin
                    wait_cyc(2);
                    psx_clk = 1'b0;
                    abort_ev.push_back(cyc + 3);
                    push_data(cyc + 3, 1'b1);
                    wait_cyc(HALF);
                    psx_clk = 1'b1;
                    ended = 1'b1;
                    how   = 2;
                end else if (i == rst_byte) begin
                    wait_cyc(ACK_DELAY + 3);
                    check("ack_low_before_rst", 64'(ack), 64'd0);
                    rst     = 1'b1;
                    att     = 1'b1;
                    psx_clk = 1'b1;
                    cmd     = 1'b1;
                    model_reset();
                    #1;
                    check("ack_async_rst", 64'(ack), 64'd1);
                    check("data_async_rst", 64'(data), 64'd1);
                    wait_cyc(3);
                    rst = 1'b0;
                    ended = 1'b1;
                    how   = 3;
                end else begin
                    ack_ev.push_back('{r + 3 + ACK_DELAY, 1'b0});
                    ack_ev.push_back('{r + 3 + ACK_DELAY + ACK_WIDTH, 1'b1});
                    wait_cyc(ACK_DELAY + ACK_WIDTH + 2 + int'($urandom_range(0, 4)));
                end
            end
        end
        if (how == 0 || how == 2) begin
            wait_cyc(HALF);
            att = 1'b1;
            if (how == 0) done_ev.push_back(cyc + 3);
        end
        wait_cyc(2 * HALF);
    endtask

    // Expected outcome of an undisturbed frame under the command rules.
    task automatic expect_frame(
        input  logic [15:0] btn,
        input  logic [39:0] cmds,
        output logic [39:0] e_got,
        output int          e_n,
        output int          e_acks,
        output int          e_done,
        output int          e_abort
    );
        bit         stop;
        logic [7:0] rb;
        e_got = '1; e_n = 0; e_acks = 0; e_done = 1; e_abort = 0;
        stop = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (!stop) begin
                rb = reply_of(i, btn);
                e_got[8*i +: 8] = rb;
                e_n += 8;
                if (cmd_rejected(i, cmds[8*i +: 8])) begin
                    stop = 1'b1; e_done = 0; e_abort = 1;
                end else if (i < 4) begin
                    e_acks++;
                end
            end
        end
    endtask

    // ---------------- stimulus ----------------
    localparam logic [39:0] STD_CMDS = 40'h00_00_00_42_01;

    logic [39:0] got;
    logic [39:0] e_got;
    int          n_got;
    int          e_n, e_acks, e_done, e_abort;
    int          k0, d0, a0;
    logic [15:0] rbtn;
    logic [39:0] rcmds;

    initial begin
        rst = 1'b1; att = 1'b1; psx_clk = 1'b1; cmd = 1'b1; buttons = '1;
        chk_en = 1'b1;
        wait_cyc(3);
        check("rst_data", 64'(data), 64'd1);
        check("rst_ack", 64'(ack), 64'd1);
        check("rst_done", 64'(frame_done), 64'd0);
        check("rst_abort", 64'(frame_abort), 64'd0);
        rst = 1'b0;
        wait_cyc(4);

        // Full frame with literal reply.
        k0 = ack_falls; d0 = done_cnt; a0 = abort_cnt;
        run_frame(16'hFFFE, 16'hFFFE, -1, STD_CMDS, -1, -1, -1, got, n_got);
        check("full_reply", 64'(got), 64'h00_FF_FE_5A_41_FF);
        check("full_bits", 64'(n_got), 64'd40);
        check("full_acks", 64'(ack_falls - k0), 64'd4);
        check("full_done", 64'(done_cnt - d0), 64'd1);
        check("full_abort", 64'(abort_cnt - a0), 64'd0);

        // Buttons change mid-frame; latched value must be returned.
        run_frame(16'h0F0F, 16'hF0F0, 2, STD_CMDS, -1, -1, -1, got, n_got);
        check("latch_btn", 64'(got[39:24]), 64'h0F0F);
        check("latch_reply", 64'(got), 64'h00_0F_0F_5A_41_FF);

        // att released after 12 bits.
        k0 = ack_falls; d0 = done_cnt; a0 = abort_cnt;
        run_frame(16'h1234, 16'h1234, -1, STD_CMDS, 12, -1, -1, got, n_got);
        check("abort_bits", 64'(n_got), 64'd12);
        check("abort_reply", 64'(got), 64'h00_FF_FF_FF_F1_FF);
        check("abort_pulse", 64'(abort_cnt - a0), 64'd1);
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        check("abort_acks", 64'(ack_falls - k0), 64'd1);
        d0 = done_cnt;
        run_frame(16'hA5C3, 16'hA5C3, -1, STD_CMDS, -1, -1, -1, got, n_got);
        check("after_abort_reply", 64'(got), 64'h00_A5_C3_5A_41_FF);
        check("after_abort_done", 64'(done_cnt - d0), 64'd1);

        // Host clocks during the ack wait after byte 0.
        k0 = ack_falls; a0 = abort_cnt;
        run_frame(16'h5555, 16'h5555, -1, STD_CMDS, -1, 0, -1, got, n_got);
        check("early_no_ack", 64'(ack_falls - k0), 64'd0);
        check("early_abort", 64'(abort_cnt - a0), 64'd1);

        // Bad start byte.
        k0 = ack_falls; d0 = done_cnt; a0 = abort_cnt;
        run_frame(16'h1234, 16'h1234, -1, 40'h00_00_00_42_81, -1, -1, -1, got, n_got);
`ifdef FAKE_PSX_PAD_STRICT_CMD_EN
        check("strict_abort", 64'(abort_cnt - a0), 64'd1);
        check("strict_no_ack", 64'(ack_falls - k0), 64'd0);
        check("strict_bits", 64'(n_got), 64'd8);
`else
        check("lax_done", 64'(done_cnt - d0), 64'd1);
        check("lax_acks", 64'(ack_falls - k0), 64'd4);
        check("lax_reply", 64'(got), 64'h00_12_34_5A_41_FF);
`endif

        // Reset during the ack pulse after byte 1, then a clean frame.
        run_frame(16'hBEEF, 16'hBEEF, -1, STD_CMDS, -1, -1, 1, got, n_got);
        d0 = done_cnt;
        run_frame(16'h00FF, 16'h00FF, -1, STD_CMDS, -1, -1, -1, got, n_got);
        check("after_rst_reply", 64'(got), 64'h00_00_FF_5A_41_FF);
        check("after_rst_done", 64'(done_cnt - d0), 64'd1);

        // Randomized frames.
        for (int f = 0; f < 8; f++) begin
            rbtn  = 16'($urandom);
            rcmds = {8'($urandom), 8'($urandom), 8'($urandom),
                     ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h42,
                     ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h01};
            expect_frame(rbtn, rcmds, e_got, e_n, e_acks, e_done, e_abort);
            k0 = ack_falls; d0 = done_cnt; a0 = abort_cnt;
            run_frame(rbtn, 16'($urandom), 2, rcmds, -1, -1, -1, got, n_got);
            check("rand_reply", 64'(got), 64'(e_got));
            check("rand_bits", 64'(n_got), 64'(e_n));
            check("rand_acks", 64'(ack_falls - k0), 64'(e_acks));
            check("rand_done", 64'(done_cnt - d0), 64'(e_done));
            check("rand_abort", 64'(abort_cnt - a0), 64'(e_abort));
        end

        wait_cyc(4);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
